d2_5enc_tx: RTL and testbench

D2_5ENC_TX -- requirements
Module: d2_5enc_tx

---
 rtl/d2_5enc_tx.sv | 100 ++++++++++
 tb/tb_d2_5enc_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/d2_5enc_tx.sv
// Serial 2-of-5 (7-4-2-1-0) BCD transmitter.
// Accepts one digit in IDLE, shifts the code out MSB first, then idles one gap cycle.
module d2_5enc_tx #(
   parameter int BIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       sout,
   output logic       sframe,
   output logic [4:0] code_out,
   output logic       err,
   output logic [7:0] frame_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   localparam logic [3:0] CYC_LAST = 4'(BIT_CYCLES - 1);

   state_t     state;
   logic [4:0] shreg;
   logic [3:0] cyc;
   logic [2:0] bitn;
   logic [4:0] code;
   logic       accept;

   always_comb begin
      code = 5'b00000;
      case (din)
         4'd0:    code = 5'b11000;
         4'd1:    code = 5'b00011;
         4'd2:    code = 5'b00101;
         4'd3:    code = 5'b00110;
         4'd4:    code = 5'b01001;
         4'd5:    code = 5'b01010;
         4'd6:    code = 5'b01100;
         4'd7:    code = 5'b10001;
         4'd8:    code = 5'b10010;
         4'd9:    code = 5'b10100;
         default: code = 5'b00000;
      endcase
   end

   assign din_ready = (state == IDLE);
   assign accept    = din_valid & din_ready;
   // shreg is zero outside SHIFT, so its MSB doubles as the serial line
   assign sout      = shreg[4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= 5'b00000;
         cyc       <= 4'd0;
         bitn      <= 3'd0;
         sframe    <= 1'b0;
         code_out  <= 5'b00000;
         err       <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (din > 4'd9) begin
                     err <= 1'b1;
                  end else begin
                     shreg    <= code;
                     code_out <= code;
                     sframe   <= 1'b1;
                     cyc      <= 4'd0;
                     bitn     <= 3'd0;
                     state    <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (cyc == CYC_LAST) begin
                  cyc <= 4'd0;
                  if (bitn == 3'd4) begin
                     shreg     <= 5'b00000;
                     sframe    <= 1'b0;
                     frame_cnt <= frame_cnt + 8'd1;
                     state     <= GAP;
                  end else begin
                     bitn  <= bitn + 3'd1;
                     shreg <= {shreg[3:0], 1'b0};
                  end
               end else begin
                  cyc <= cyc + 4'd1;
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_d2_5enc_tx.sv
// Randomized bench for d2_5enc_tx at BIT_CYCLES 1 and 3.
// A timing model predicts every output cycle; sout is also decoded back to the digit.
module tb_d2_5enc_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] dv = 2'b00;
   logic [1:0] sout, sframe, rdy, err;
   logic [3:0] din [2];
   logic [4:0] cout [2];
   logic [7:0] fcnt [2];

   always #5 clk = ~clk;

   d2_5enc_tx #(.BIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .din(din[0]), .din_valid(dv[0]),
      .din_ready(rdy[0]), .sout(sout[0]), .sframe(sframe[0]),
      .code_out(cout[0]), .err(err[0]), .frame_cnt(fcnt[0])
   );

   d2_5enc_tx #(.BIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .din(din[1]), .din_valid(dv[1]),
      .din_ready(rdy[1]), .sout(sout[1]), .sframe(sframe[1]),
      .code_out(cout[1]), .err(err[1]), .frame_cnt(fcnt[1])
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(string tag, int got, int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   int         bcv [2] = '{1, 3};
   int         n = 0;
   int         start [2] = '{0, 0};
   bit         act [2] = '{0, 0};
   logic [4:0] m_code [2] = '{5'd0, 5'd0};
   int         m_cnt [2] = '{0, 0};
   int         m_din [2] = '{0, 0};
   bit         m_err [2] = '{0, 0};
   int         err_seen [2] = '{0, 0};
   int         lb_n [2] = '{0, 0};
   logic [4:0] lb_v [2] = '{5'd0, 5'd0};
   int         q0 [$];
   int         q1 [$];
   bit         jit = 1'b0;
   logic [4:0] tbl [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                            5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

   function automatic bit busy(int i, int m);
      return act[i] && (m - start[i]) <= 5 * bcv[i];
   endfunction

   function automatic int qsize(int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic int qfront(int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpop(int i);
      if (i == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
   endtask

   // weights 7,4,2,1,0 from bit 4 down; 7+4 stands for zero
   function automatic int decode(logic [4:0] c);
      int w [5] = '{0, 1, 2, 4, 7};
      int s = 0;
      int ones = 0;
      for (int b = 0; b < 5; b++) begin
         if (c[b]) begin
            s += w[b];
            ones++;
         end
      end
      if (ones != 2) return -1;
      return (s == 11) ? 0 : s;
   endfunction

   task automatic model_edge(int i);
      m_err[i] = 1'b0;
      if (act[i] && (n - 1 - start[i]) == 5 * bcv[i] - 1)
         m_cnt[i] = (m_cnt[i] + 1) % 256;
      if (!busy(i, n - 1) && dv[i]) begin
         if (din[i] <= 4'd9) begin
            act[i]    = 1'b1;
            start[i]  = n;
            m_code[i] = tbl[din[i]];
            m_din[i]  = int'(din[i]);
         end else begin
            m_err[i] = 1'b1;
         end
         qpop(i);
      end
   endtask

   task automatic compare(int i);
      int   k = n - start[i];
      int   b = bcv[i];
      logic es = 1'b0;
      logic ef = 1'b0;
      logic er = 1'b1;
      if (act[i] && k < 5 * b) begin
         ef = 1'b1;
         es = m_code[i][4 - k / b];
         er = 1'b0;
      end else if (act[i] && k == 5 * b) begin
         er = 1'b0;
      end
      check($sformatf("sout%0d", i), sout[i], es);
      check($sformatf("sframe%0d", i), sframe[i], ef);
      check($sformatf("ready%0d", i), rdy[i], er);
      check($sformatf("err%0d", i), err[i], m_err[i]);
      check($sformatf("code_out%0d", i), cout[i], m_code[i]);
      check($sformatf("frame_cnt%0d", i), fcnt[i], m_cnt[i]);
      if (err[i]) err_seen[i]++;
      if (sframe[i]) begin
         if (lb_n[i] % b == 0) lb_v[i] = {lb_v[i][3:0], sout[i]};
         lb_n[i]++;
      end else if (lb_n[i] != 0) begin
         check($sformatf("frame_len%0d", i), lb_n[i], 5 * b);
         check($sformatf("loopback%0d", i), decode(lb_v[i]), m_din[i]);
         check($sformatf("two_ones%0d", i), $countones(cout[i]), 2);
         lb_n[i] = 0;
      end
   endtask

   task automatic step();
      for (int i = 0; i < 2; i++) begin
         if (busy(i, n)) begin
            din[i] = 4'($urandom);
            dv[i]  = jit ? 1'($urandom) : (qsize(i) != 0);
         end else if (qsize(i) != 0) begin
            din[i] = 4'(qfront(i));
            dv[i]  = !jit || ($urandom_range(0, 3) != 0);
         end else begin
            din[i] = 4'($urandom);
            dv[i]  = 1'b0;
         end
      end
      @(posedge clk);
      n++;
      if (!reset) begin
         for (int i = 0; i < 2; i++) model_edge(i);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) compare(i);
   endtask

   task automatic run_idle(int maxc);
      int c = 0;
      while ((qsize(0) != 0 || qsize(1) != 0 || busy(0, n) || busy(1, n))
             && c < maxc) begin
         step();
         c++;
      end
      if (c >= maxc) check("timeout", 1, 0);
      repeat (2) step();
   endtask

   task automatic pulse_reset(int cyc);
      #2 reset = 1'b1;
      #1;
      act    = '{0, 0};
      m_cnt  = '{0, 0};
      m_code = '{5'd0, 5'd0};
      m_err  = '{0, 0};
      lb_n   = '{0, 0};
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_sout%0d", i), sout[i], 0);
         check($sformatf("rst_sframe%0d", i), sframe[i], 0);
         check($sformatf("rst_cnt%0d", i), fcnt[i], 0);
         check($sformatf("rst_code%0d", i), cout[i], 0);
         check($sformatf("rst_err%0d", i), err[i], 0);
         check($sformatf("rst_ready%0d", i), rdy[i], 1);
      end
      repeat (cyc) step();
      reset = 1'b0;
   endtask

   initial begin
      int c;
      din[0] = 4'd0;
      din[1] = 4'd0;

      // digits offered while reset is held must wait for release
      q0.push_back(3);
      q1.push_back(3);
      repeat (3) step();
      reset = 1'b0;
      run_idle(100);
      check("cnt_after_release", fcnt[0], 1);
      check("code3", cout[0], 5'b00110);

      // digits 0..9 back to back with valid held high
      pulse_reset(2);
      for (int d = 0; d < 10; d++) q0.push_back(d);
      q1.push_back(7);
      run_idle(500);
      check("cnt_0to9", fcnt[0], 10);
      check("code7_bc3", cout[1], 5'b10001);
      check("cnt_bc3", fcnt[1], 1);

      // out-of-range digits
      err_seen[0] = 0;
      q0.push_back(12);
      run_idle(50);
      q0.push_back(15);
      run_idle(50);
      check("err_cycles", err_seen[0], 2);
      check("code_keep", cout[0], 5'b10100);
      check("cnt_keep", fcnt[0], 10);

      // reset during the third bit of digit 5
      q0.push_back(5);
      c = 0;
      while (!(act[0] && m_din[0] == 5 && n - start[0] == 2) && c < 100) begin
         step();
         c++;
      end
      if (c >= 100) check("timeout_abort", 1, 0);
      check("third_bit_sframe", sframe[0], 1);
      pulse_reset(2);
      q0.push_back(2);
      run_idle(100);
      check("cnt_after_abort", fcnt[0], 1);
      check("code2", cout[0], 5'b00101);

      // random traffic with toggling valid; enough good frames to wrap
      jit = 1'b1;
      for (int j = 0; j < 280; j++) begin
         q0.push_back($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) q0.push_back($urandom_range(10, 15));
      end
      for (int j = 0; j < 80; j++) q1.push_back($urandom_range(0, 15));
      run_idle(20000);
      check("wrap_cnt", fcnt[0], (1 + 280) % 256);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
